// File: rtl/pumpeds_pkg.sv
// Shared definitions for the pumpeds fetch/decode front end.
//   INSTR_W          : instruction word width
//   OPC_LSB/OPC_MSB  : position of the opcode-type field within a word
//   opc_type_e       : 4-bit opcode-type encoding shared with the decoder
//   fetch_state_e    : instruction-fetch request state
package pumpeds_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OPC_LSB = 24;
  localparam int unsigned OPC_MSB = 27;

  typedef enum logic [3:0] {
    OPC_ALU        = 4'd0,
    OPC_FALU       = 4'd1,
    OPC_COND       = 4'd2,
    OPC_JUMP       = 4'd3,
    OPC_RAM_SAVE   = 4'd4,
    OPC_RAM_LOAD   = 4'd5,
    OPC_HALT       = 4'd6,
    OPC_STACK_PUSH = 4'd7,
    OPC_STACK_POP  = 4'd8,
    OPC_CALL       = 4'd9,
    OPC_RET        = 4'd10
  } opc_type_e;

  // IDLE: no request; BUSY: request whose data will be kept;
  // DROP: request whose data is discarded (issued before a redirect).
  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_BUSY,
    FETCH_DROP
  } fetch_state_e;

  function automatic opc_type_e opc_type_of(input logic [INSTR_W-1:0] w);
    return opc_type_e'(w[OPC_MSB:OPC_LSB]);
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO of {instruction word, pc} pairs for the fetch stage.
// Ports:
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   flush_i            : empty the FIFO (wins over push_i)
//   push_i, word_i, pc_i : write an entry (ignored when full)
//   pop_i              : consume the head (ignored when empty)
//   valid_o, word_o, pc_o : head entry
//   count_o            : number of stored entries
module ifetch_fifo
  import pumpeds_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               push_i,
  input  logic [INSTR_W-1:0] word_i,
  input  logic [31:0]        pc_i,
  input  logic               pop_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] word_o,
  output logic [31:0]        pc_o,
  output logic [AW:0]        count_o
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [INSTR_W-1:0] word_mem [DEPTH];
  logic [31:0]        pc_mem   [DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [AW:0]        count_q;
  logic               do_push, do_pop;

  assign do_push = push_i && (count_q != DEPTH_C);
  assign do_pop  = pop_i && (count_q != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) begin
      word_mem[wr_ptr_q] <= word_i;
      pc_mem[wr_ptr_q]   <= pc_i;
    end
  end

  assign valid_o = (count_q != '0);
  assign word_o  = word_mem[rd_ptr_q];
  assign pc_o    = pc_mem[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: walks a word-aligned PC, issues single-outstanding
// reads to instruction memory, buffers returned words and presents them to
// the decoder with a valid/ready handshake. Handles downstream redirects.
// Optional HALT detection is enabled by defining IFETCH_HALT_DETECT_EN.
// Ports:
//   clk, rst (async, active-low)
//   imem_req/imem_addr   : read request, held until imem_ack
//   imem_ack/imem_rdata  : read response
//   redirect_valid/addr  : flush and restart at redirect_addr (word aligned)
//   op_valid/op_ready    : handshake to decoder; op_code/op_pc = head entry
//   halted               : fetch stopped after a HALT word (0 when disabled)
module instr_fetch
  import pumpeds_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int unsigned DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_addr,
  output logic               op_valid,
  input  logic               op_ready,
  output logic [INSTR_W-1:0] op_code,
  output logic [31:0]        op_pc,
  output logic               halted
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  addr_q, addr_d;
  logic [AW:0]  fifo_count;
  logic [31:0]  redirect_pc;
  logic         accept;
  logic         halt_stop;
  logic         unused_redirect_lsbs;

  assign redirect_pc          = {redirect_addr[31:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_addr[1:0];

  // Only a BUSY request's data is kept; a redirect in the ack cycle discards
  // it directly, so the DROP state is never needed for that case.
  assign accept = (state_q == FETCH_BUSY) && imem_ack && !redirect_valid;

`ifdef IFETCH_HALT_DETECT_EN
  logic halted_q, halted_d;

  always_comb begin
    halted_d = halted_q;
    if (redirect_valid)
      halted_d = 1'b0;
    else if (accept && (opc_type_of(imem_rdata) == OPC_HALT))
      halted_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) halted_q <= 1'b0;
    else      halted_q <= halted_d;
  end

  assign halt_stop = halted_q;
  assign halted    = halted_q;
`else
  assign halt_stop = 1'b0;
  assign halted    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pc_d    = pc_q;

    case (state_q)
      FETCH_IDLE: begin
        if (!redirect_valid && !halt_stop && (fifo_count < DEPTH_C)) begin
          state_d = FETCH_BUSY;
          addr_d  = pc_q;
        end
      end
      FETCH_BUSY: begin
        if (imem_ack)            state_d = FETCH_IDLE;
        else if (redirect_valid) state_d = FETCH_DROP;
      end
      FETCH_DROP: begin
        if (imem_ack) state_d = FETCH_IDLE;
      end
      default: state_d = FETCH_IDLE;
    endcase

    if (redirect_valid) pc_d = redirect_pc;
    else if (accept)    pc_d = pc_q + 32'd4;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  end

  assign imem_req  = (state_q != FETCH_IDLE);
  assign imem_addr = addr_q;

  ifetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .flush_i (redirect_valid),
    .push_i  (accept),
    .word_i  (imem_rdata),
    .pc_i    (addr_q),
    .pop_i   (op_valid && op_ready),
    .valid_o (op_valid),
    .word_o  (op_code),
    .pc_o    (op_pc),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] op_code;
  logic [31:0] op_pc;
  logic        halted;

  int checks;
  int errors;
  logic auto_mem;
  logic halt_mode;

  instr_fetch #(
    .RESET_PC (32'h0),
    .DEPTH    (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .op_valid       (op_valid),
    .op_ready       (op_ready),
    .op_code        (op_code),
    .op_pc          (op_pc),
    .halted         (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (halt_mode && (a == 32'h8)) return 32'h0600_0000;
    return {8'hC0, a[23:0]} ^ 32'h0055_AA00;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample point is 1 time unit after the rising edge; the
  // optional memory model then answers any pending request in this cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_mem) begin
      if (imem_req) begin
        imem_ack   = 1'b1;
        imem_rdata = memword(imem_addr);
      end else begin
        imem_ack = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst            = 1'b0;
    auto_mem       = 1'b0;
    imem_ack       = 1'b0;
    redirect_valid = 1'b0;
    #1;
    chk("rst_req",    {31'd0, imem_req}, 32'd0);
    chk("rst_valid",  {31'd0, op_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted},   32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic drain_n(input logic [31:0] start, input int n);
    logic [31:0] exp_pc;
    int got;
    int budget;
    exp_pc = start;
    got    = 0;
    budget = 0;
    while (got < n && budget < 60) begin
      if (op_valid && op_ready) begin
        chk("op_pc",   op_pc,   exp_pc);
        chk("op_code", op_code, memword(exp_pc));
        exp_pc = exp_pc + 32'd4;
        got++;
      end
      tick();
      budget++;
    end
    chk("drain_count", got, n);
  endtask

  task automatic wait_req(input logic [31:0] addr);
    int budget;
    budget = 0;
    while (!(imem_req && imem_addr == addr) && budget < 10) begin
      tick();
      budget++;
    end
    chk("wait_req_addr", {31'd0, imem_req}, 32'd1);
    chk("wait_req_val",  imem_addr, addr);
  endtask

  initial begin
    int acks;
    int reqs;
    checks         = 0;
    errors         = 0;
    rst            = 1'b1;
    auto_mem       = 1'b0;
    halt_mode      = 1'b0;
    imem_ack       = 1'b0;
    imem_rdata     = '0;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    op_ready       = 1'b0;
    #2;

    // Streaming with 1-cycle memory and an always-ready decoder
    do_reset();
    auto_mem = 1'b1;
    op_ready = 1'b1;
    tick();
    chk("first_req",  {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    chk("first_noval", {31'd0, op_valid}, 32'd0);
    tick();
    chk("lat_valid", {31'd0, op_valid}, 32'd1);
    chk("lat_pc",    op_pc, 32'h0);
    chk("lat_code",  op_code, memword(32'h0));
    chk("lat_reqlo", {31'd0, imem_req}, 32'd0);
    drain_n(32'h0, 8);

    // Back-pressure: only DEPTH fetches, head stays stable
    do_reset();
    auto_mem = 1'b1;
    op_ready = 1'b0;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (imem_req && imem_ack) acks++;
    end
    chk("bp_acks",  acks, 2);
    chk("bp_req",   {31'd0, imem_req}, 32'd0);
    chk("bp_valid", {31'd0, op_valid}, 32'd1);
    chk("bp_pc",    op_pc, 32'h0);
    chk("bp_code",  op_code, memword(32'h0));
    op_ready = 1'b1;
    drain_n(32'h0, 4);

    // Redirect while a request is outstanding; ack arrives 3 cycles later
    do_reset();
    op_ready = 1'b1;
    tick();
    chk("rd_req0", {31'd0, imem_req}, 32'd1);
    redirect_valid = 1'b1;
    redirect_addr  = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0;
    chk("rd_hold_req",  {31'd0, imem_req}, 32'd1);
    chk("rd_hold_addr", imem_addr, 32'h0);
    tick();
    tick();
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    chk("rd_drop_req",   {31'd0, imem_req}, 32'd0);
    chk("rd_drop_valid", {31'd0, op_valid}, 32'd0);
    tick();
    chk("rd_new_req",   {31'd0, imem_req}, 32'd1);
    chk("rd_new_addr",  imem_addr, 32'h100);
    chk("rd_new_valid", {31'd0, op_valid}, 32'd0);
    auto_mem = 1'b1;
    drain_n(32'h100, 2);

    // Redirect, ack and pop in the same cycle; then a stray ack while idle
    do_reset();
    op_ready = 1'b0;
    tick();
    imem_ack   = 1'b1;
    imem_rdata = memword(32'h0);
    tick();
    imem_ack = 1'b0;
    tick();
    chk("rap_req",   {31'd0, imem_req}, 32'd1);
    chk("rap_addr",  imem_addr, 32'h4);
    chk("rap_valid", {31'd0, op_valid}, 32'd1);
    chk("rap_pc",    op_pc, 32'h0);
    redirect_valid = 1'b1;
    redirect_addr  = 32'h200;
    imem_ack       = 1'b1;
    imem_rdata     = memword(32'h4);
    op_ready       = 1'b1;
    tick();
    redirect_valid = 1'b0;
    imem_rdata     = 32'hBAD0_0BAD;
    chk("rap_empty", {31'd0, op_valid}, 32'd0);
    chk("rap_idle",  {31'd0, imem_req}, 32'd0);
    tick();
    imem_ack = 1'b0;
    chk("rap_next_req",  {31'd0, imem_req}, 32'd1);
    chk("rap_next_addr", imem_addr, 32'h200);
    chk("late_ack_ign",  {31'd0, op_valid}, 32'd0);
    auto_mem = 1'b1;
    drain_n(32'h200, 2);

    // HALT word at 0x8
    do_reset();
    halt_mode = 1'b1;
    auto_mem  = 1'b1;
    op_ready  = 1'b1;
    drain_n(32'h0, 3);
    reqs = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (imem_req) reqs++;
    end
`ifdef IFETCH_HALT_DETECT_EN
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_noreq", reqs, 0);
`else
    chk("halt_flag", {31'd0, halted}, 32'd0);
    chk("halt_runs", {31'd0, (reqs != 0)}, 32'd1);
`endif
    redirect_valid = 1'b1;
    redirect_addr  = 32'h0;
    tick();
    redirect_valid = 1'b0;
    chk("halt_clear", {31'd0, halted}, 32'd0);
    wait_req(32'h0);
    drain_n(32'h0, 2);
    halt_mode = 1'b0;

    // PC wrap at the top of the address space
    do_reset();
    op_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_addr  = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    chk("wrap_noreq", {31'd0, imem_req}, 32'd0);
    tick();
    chk("wrap_req",  {31'd0, imem_req}, 32'd1);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    auto_mem = 1'b1;
    drain_n(32'hFFFF_FFFC, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage, directly upstream of the opcode-type decoder. It walks a word-aligned program counter, issues single-outstanding reads to instruction memory, and buffers returned 32-bit instruction words in a small FIFO. It presents them to the decoder with a valid/ready handshake. It also handles control-flow redirects (JUMP/COND/CALL/RET resolved downstream) and stops fetching after a HALT.

## Interface
- `RESET_PC`, default `32'h0`: PC loaded at reset; must be 4-byte aligned.
- `DEPTH`, default `2`: instruction FIFO entries, power of two, ≥2.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `imem_req`  out  1  read request; held high until `imem_ack`.
- `imem_addr`  out  32  byte address of requested word; stable while `imem_req` is high.
- `imem_ack`  in  1  response strobe; `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  instruction word.
- `redirect_valid`  in  1  one-cycle pulse: flush and restart at `redirect_addr`.
- `redirect_addr`  in  32  new PC; bits [1:0] ignored (forced 0).
- `op_valid`  out  1  FIFO head valid.
- `op_ready`  in  1  decoder accepts head.
- `op_code`  out  32  head instruction word; feeds decoder `Op_code`.
- `op_pc`  out  32  address of head instruction.
- `halted`  out  1  fetch stopped on HALT (only with the configuration macro).

## Operation
- Reset: `pc`=`RESET_PC`, FIFO empty, `imem_req`=0, `op_valid`=0, `halted`=0, drop flag=0. `op_code`/`op_pc` are don't-care while `op_valid`=0.
- Issue condition: no request outstanding, `halted`=0, no `redirect_valid` this cycle, and FIFO count + 1 ≤ `DEPTH`. A slot is reserved at issue.
- On `imem_ack` with drop flag clear: push {`imem_rdata`, `imem_addr`}; `pc` += 4. `pc` wraps modulo 2^32 (0xFFFFFFFC → 0x0).
- Pop when `op_valid && op_ready`.
- Redirect: FIFO flushed; `pc` ← `{redirect_addr[31:2],2'b00}`; `halted` cleared.
  - A request still outstanding sets the drop flag. Its ack is discarded and clears the flag.
  - `imem_req` stays high until that ack (protocol never retracts a request).
- Redirect and `imem_ack` in the same cycle: that data is dropped, and no drop flag is needed afterward.
- Redirect and pop in the same cycle: the pop counts as consumed, then the flush happens.
- Opcode type is `imem_rdata[27:24]`. HALT = 6.

## Timing
- Earliest `imem_req` is the first edge after `rst` deasserts.
- Fetch latency is ack cycle + 1: `op_valid` rises the edge after `imem_ack`.
- Back-to-back: a new request may assert on the edge following `imem_ack`, giving at most one word per 2 cycles when memory acks in 1 cycle.
- Full FIFO with `op_ready`=0: no new request; `op_valid`, `op_code` and `op_pc` hold stable.
- First request to the new target asserts:
  - the cycle after a redirect if nothing is outstanding;
  - otherwise the cycle after the dropped ack.
- `rst` mid-transaction: all state clears immediately. Any late `imem_ack` while `imem_req`=0 is ignored.

## Configuration
- `IFETCH_HALT_DETECT_EN` defined:
  - An accepted (non-dropped) ack whose opcode type is HALT sets `halted` on the same edge as the push.
  - No further requests are issued until `redirect_valid` or reset.
  - The HALT word itself is still delivered to the decoder.
- Not defined: `halted` is tied to 0 and fetch runs continuously; the downstream decoder's HALT output must stall the pipeline.

## Structure
- Shared package `pumpeds_pkg`:
  - 4-bit opcode-type enum: ALU=0, FALU=1, COND=2, JUMP=3, RAM_SAVE=4, RAM_LOAD=5, HALT=6, STACK_PUSH=7, STACK_POP=8, CALL=9, RET=10.
  - Opcode field position constants (bits 27:24).
  - `INSTR_W`=32.
- Sub-module `ifetch_fifo`: synchronous FIFO of {word, pc}, with count, push, pop and flush; flush has priority over push.

## Test plan
- Reset then memory acks 1 cycle after every req, `op_ready`=1 → `op_pc` sequence 0x0, 0x4, 0x8, … with the matching `op_code` words.
- `op_ready`=0 for 10 cycles → exactly `DEPTH` requests issued, then `imem_req` stays low, and the head word holds stable.
- Redirect to 0x100 while a request is outstanding, ack 3 cycles later → that word is never presented; the next request has `imem_addr`=0x100.
- Redirect, `imem_ack` and pop all in the same cycle → the acked word is discarded, the FIFO is empty next cycle, and the next `imem_addr` is the redirect target.
- With `IFETCH_HALT_DETECT_EN`, word 0x06000000 at 0x8 → that word is delivered, `halted`=1, and no request follows. A redirect to 0x0 resumes fetch.
- PC at 0xFFFFFFFC → the next fetch address is 0x00000000.
